fp_mul_arbiter: RTL
===================

Name: fp_mul_arbiter

Overview:
- Shares one clocked FP16 multiplier (`float_multi`) among N requesters in the 8-point FFT datapath, e.g. the butterfly twiddle-multiply lanes.
- Round-robin arbitration on a valid/ready request interface.
- Issues operands to the multiplier and tracks each request's ID through the multiplier latency.
- Returns the product and status flags tagged with the originating requester ID.

Parameters:
- N, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal ceil(log2(N)), minimum 1.
- MUL_LAT, 1, cycles from `mul_in_valid`/operands at the multiplier input to a valid `mul_result` (0 = combinational).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N  per-requester request valid.
- req_a  input  16*N  operand A, FP16; requester i occupies bits [16i+15:16i].
- req_b  input  16*N  operand B, FP16, same packing as req_a.
- req_ready  output  N  one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both high.
- mul_a  output  16  operand A to the multiplier.
- mul_b  output  16  operand B to the multiplier.
- mul_in_valid  output  1  operands on mul_a/mul_b are a real issue.
- mul_result  input  16  multiplier product.
- mul_flags  input  4  {overflow, zero, nan, precisionLost} from the multiplier.
- resp_valid  output  1  one-cycle pulse, response present.
- resp_id  output  ID_W  requester that owns the response.
- resp_result  output  16  product.
- resp_flags  output  4  flags, same ordering as mul_flags.
- busy  output  1  at least one operation issued and not yet responded.
- resp_count  output  16  number of responses delivered; wraps.

Behaviour:
- Synchronous reset (rst high at a rising edge) sets:
  - rr_ptr = 0;
  - mul_a, mul_b, mul_in_valid, resp_valid, resp_id, resp_result, resp_flags, resp_count = 0;
  - all in-flight tags invalid.
- req_ready is combinationally 0 while rst is high.
- Arbitration is combinational within the cycle:
  - Grant g is the first i with req_valid[i] = 1, searching cyclically from rr_ptr.
  - req_ready = one-hot(g); req_ready = 0 if no requester is valid.
  - Exactly one grant per cycle, maximum; throughput is one issue per cycle.
- On a handshake in cycle T (sampled at the end of T):
  - mul_a <= req_a[g], mul_b <= req_b[g], mul_in_valid <= 1, valid during T+1.
  - rr_ptr <= (g+1) mod N.
- No handshake: mul_in_valid <= 0; mul_a/mul_b hold their previous value; rr_ptr unchanged.
- req_ready does not depend on req_valid of the same requester beyond the arbitration logic. A requester may drop req_valid without a handshake (no stickiness).
- Tag pipeline:
  - Shift register of depth MUL_LAT carrying {valid, id}, advanced every cycle, in lockstep with the multiplier.
  - The tag entering at cycle T+1 aligns with mul_result at cycle T+1+MUL_LAT.
  - MUL_LAT = 0: no shift stages; the tag is aligned with mul_in_valid directly.
- Response stage (registered):
  - When the aligned tag is valid, at the end of cycle T+1+MUL_LAT: resp_result <= mul_result, resp_flags <= mul_flags, resp_id <= tag id, resp_valid <= 1.
  - Otherwise resp_valid <= 0; resp_result/resp_flags/resp_id hold.
  - resp_valid is therefore high in cycle T+2+MUL_LAT; end-to-end latency is MUL_LAT+2.
- No response backpressure: consumers must accept resp_valid whenever it is asserted.
- resp_count increments by 1 on every cycle resp_valid is registered high; it wraps from 0xFFFF to 0.
- busy = mul_in_valid OR any valid tag OR resp_valid (registered terms only; no combinational dependence on inputs).
- Responses return in issue order. Back-to-back issues give back-to-back resp_valid pulses.
- Reset mid-operation: all in-flight tags are discarded and no resp_valid is produced for them. Requesters must re-issue.
- A requester holding req_valid continuously is served at most once every N cycles when all N requesters are valid (fairness).
- The flag vector passes through unmodified. The arbiter never inspects the FP16 values.

Test Plan:
- Single request, N=4, MUL_LAT=1, bench multiplier model. Requester 2 presents A=0xC200 (-3), B=0xB9A8 (-0.707) at cycle T.
  -> req_ready=4'b0100 in T; mul_in_valid high in T+1; resp_valid, resp_id=2, resp_result=0x403E in T+3; resp_count=1; busy high T+1..T+3, then low.
- All four requesters valid continuously for 8 cycles with distinct operands (req0 0xBC00*0x39A8 -> 0xB9A8; req1 0xBC00*0xB9A8 -> 0x39A8; req3 0xC200*0x39A8 -> 0xC03E; req2 as above).
  -> grant order 0,1,2,3,0,1,2,3; resp_id order identical; 8 consecutive resp_valid pulses; resp_count=8.
- rr_ptr=2, only requesters 0 and 3 valid.
  -> grant 3 first, then 0; rr_ptr becomes 0, then 1.
- Requester 1 raises req_valid for one cycle while requester 0 is granted, then drops it.
  -> no issue and no response for requester 1.
- Assert rst for 1 cycle, 1 cycle after two issues.
  -> no resp_valid for either request; all outputs 0; busy 0 the cycle after reset; next request gets a normal MUL_LAT+2 latency.
- MUL_LAT=3 and MUL_LAT=0 builds, one request each.
  -> resp_valid at T+5 and T+2 respectively; resp_flags equals the model's {overflow, zero, nan, precisionLost}, including 0x7C00*0x0000 producing the nan flag.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP16 multiplier among N requesters.
// Tags each issue with its requester ID and returns results in issue order.
module fp_mul_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [16*N-1:0]   req_a,
    input  logic [16*N-1:0]   req_b,
    output logic [N-1:0]      req_ready,
    output logic [15:0]       mul_a,
    output logic [15:0]       mul_b,
    output logic              mul_in_valid,
    input  logic [15:0]       mul_result,
    input  logic [3:0]        mul_flags,
    output logic              resp_valid,
    output logic [ID_W-1:0]   resp_id,
    output logic [15:0]       resp_result,
    output logic [3:0]        resp_flags,
    output logic              busy,
    output logic [15:0]       resp_count
);

    logic [ID_W-1:0] rr_ptr_q;
    logic [15:0]     mul_a_q, mul_b_q;
    logic            mul_in_valid_q;
    logic [ID_W-1:0] mul_id_q;
    logic            resp_valid_q;
    logic [ID_W-1:0] resp_id_q;
    logic [15:0]     resp_result_q;
    logic [3:0]      resp_flags_q;
    logic [15:0]     resp_count_q;

    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] rr_ptr_d;
    logic            handshake;
    int unsigned     idx;

    // Cyclic search for the first valid requester starting at rr_ptr_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < int'(N); k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    assign handshake = grant_vld & ~rst;
    assign req_ready = handshake ? (N'(1) << grant_id) : '0;
    assign rr_ptr_d  = ID_W'((int'(grant_id) + 1) % N);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            mul_in_valid_q <= 1'b0;
            mul_id_q       <= '0;
        end else begin
            mul_in_valid_q <= handshake;
            if (handshake) begin
                mul_a_q  <= req_a[16*grant_id +: 16];
                mul_b_q  <= req_b[16*grant_id +: 16];
                mul_id_q <= grant_id;
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    logic            al_vld;
    logic [ID_W-1:0] al_id;
    logic            tags_busy;

    if (MUL_LAT == 0) begin : g_nolat
        assign al_vld    = mul_in_valid_q;
        assign al_id     = mul_id_q;
        assign tags_busy = 1'b0;
    end else begin : g_lat
        logic [MUL_LAT-1:0] tag_vld_q;
        logic [ID_W-1:0]    tag_id_q [MUL_LAT];

        // Tags shift in lockstep with the multiplier pipeline.
        always_ff @(posedge clk) begin
            if (rst) begin
                tag_vld_q <= '0;
                for (int i = 0; i < int'(MUL_LAT); i++) begin
                    tag_id_q[i] <= '0;
                end
            end else begin
                tag_vld_q[0] <= mul_in_valid_q;
                tag_id_q[0]  <= mul_id_q;
                for (int i = 1; i < int'(MUL_LAT); i++) begin
                    tag_vld_q[i] <= tag_vld_q[i-1];
                    tag_id_q[i]  <= tag_id_q[i-1];
                end
            end
        end

        assign al_vld    = tag_vld_q[MUL_LAT-1];
        assign al_id     = tag_id_q[MUL_LAT-1];
        assign tags_busy = |tag_vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            resp_count_q  <= '0;
        end else begin
            resp_valid_q <= al_vld;
            if (al_vld) begin
                resp_id_q     <= al_id;
                resp_result_q <= mul_result;
                resp_flags_q  <= mul_flags;
                resp_count_q  <= resp_count_q + 16'd1;
            end
        end
    end

    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign mul_in_valid = mul_in_valid_q;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_result  = resp_result_q;
    assign resp_flags   = resp_flags_q;
    assign resp_count   = resp_count_q;
    assign busy         = mul_in_valid_q | tags_busy | resp_valid_q;

endmodule
